// File: rtl/dcache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sa
//  Purpose  : Set-associative, write-back, write-allocate data cache for the
//             MEM stage. It sits between the EX/MEM register (p1_*) and the
//             256-bit line memory (mem_*). Victims are chosen per set in
//             round-robin order.
//  Options  : define DCACHE_SA_STATS_EN to enable the 16-bit saturating
//             hit/miss counters; otherwise both counter ports are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module dcache_sa #(
    parameter int WAYS   = 2,
    parameter int SETS   = 32,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [15:0]       hit_cnt_o,
    output logic [15:0]       miss_cnt_o
);

    localparam int c_OFF_W = $clog2(LINE_W / 8);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = ADDR_W - c_IDX_W - c_OFF_W;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [c_WAY_W-1:0] c_WAY_MASK = c_WAY_W'(WAYS - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WB   = 2'd1;
    localparam logic [1:0] c_S_RD   = 2'd2;
    localparam logic [1:0] c_S_FILL = 2'd3;

    // Address fields of the current request
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic [c_OFF_W-3:0]   w_word;
    logic [c_OFF_W+2:0]   w_lsb;
    logic                 w_unused_addr;

    assign w_idx         = p1_addr_i[c_OFF_W +: c_IDX_W];
    assign w_tag         = p1_addr_i[ADDR_W-1 -: c_TAG_W];
    assign w_word        = p1_addr_i[c_OFF_W-1:2];
    assign w_lsb         = {w_word, 5'd0};
    assign w_unused_addr = ^p1_addr_i[1:0];

    // Per way/set storage; only the control bits are reset
    logic [WAYS-1:0]    r_valid [SETS];
    logic [WAYS-1:0]    r_dirty [SETS];
    logic [c_WAY_W-1:0] r_rr    [SETS];
    logic [c_TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]  r_line  [WAYS][SETS];

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_WAY_W-1:0] r_victim;
    logic [LINE_W-1:0]  r_fill_line;

    logic               w_access;
    logic               w_is_write;
    logic               w_hit;
    logic [c_WAY_W-1:0] w_hit_way;
    logic [c_WAY_W-1:0] w_rr_way;
    logic               w_miss_start;
    logic               w_hit_done;

    assign w_access   = p1_MemRead_i | p1_MemWrite_i;
    assign w_is_write = p1_MemWrite_i;
    assign w_rr_way   = r_rr[w_idx];

    // Tag compare across all ways of the indexed set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    // Next-state and output decode; reset forces every output low at once
    always_comb begin
        w_next       = r_state;
        p1_data_o    = '0;
        p1_stall_o   = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        w_miss_start = 1'b0;
        w_hit_done   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_access) begin
                    if (w_hit) begin
                        w_hit_done = 1'b1;
                        if (!w_is_write) begin
                            p1_data_o = r_line[w_hit_way][w_idx][w_lsb +: 32];
                        end
                    end else begin
                        p1_stall_o   = 1'b1;
                        w_miss_start = 1'b1;
                        w_next = (r_valid[w_idx][w_rr_way] && r_dirty[w_idx][w_rr_way])
                                 ? c_S_WB : c_S_RD;
                    end
                end
            end
            c_S_WB: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[r_victim][w_idx], w_idx, {c_OFF_W{1'b0}}};
                mem_data_o   = r_line[r_victim][w_idx];
                if (mem_ack_i) begin
                    w_next = c_S_RD;
                end
            end
            c_S_RD: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_idx, {c_OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_next = c_S_FILL;
                end
            end
            c_S_FILL: begin
                p1_stall_o = 1'b1;
                w_next     = c_S_IDLE;
            end
            default: w_next = c_S_IDLE;
        endcase
        if (rst_i) begin
            p1_data_o    = '0;
            p1_stall_o   = 1'b0;
            mem_enable_o = 1'b0;
            mem_write_o  = 1'b0;
            mem_addr_o   = '0;
            mem_data_o   = '0;
            w_miss_start = 1'b0;
            w_hit_done   = 1'b0;
        end
    end

    // State register, victim latch, refill capture and valid/dirty/rr bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_S_IDLE;
            r_victim    <= '0;
            r_fill_line <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_miss_start) begin
                r_victim <= w_rr_way;
            end
            if ((r_state == c_S_RD) && mem_ack_i) begin
                r_fill_line <= mem_data_i;
            end
            if (w_hit_done && w_is_write) begin
                r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (r_state == c_S_FILL) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                r_rr[w_idx]              <= (r_rr[w_idx] + 1'b1) & c_WAY_MASK;
            end
        end
    end

    // Tag and data arrays: store-hit word update and line install on fill
    always_ff @(posedge clk_i) begin
        if (w_hit_done && w_is_write) begin
            r_line[w_hit_way][w_idx][w_lsb +: 32] <= p1_data_i;
        end
        if (r_state == c_S_FILL) begin
            r_line[r_victim][w_idx] <= r_fill_line;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

`ifdef DCACHE_SA_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        r_refill_done;

    // Saturating counters; the refill-done flag keeps a miss's completing hit out of the hit count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_refill_done <= 1'b0;
        end else begin
            if (w_miss_start && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
            if (w_hit_done && !r_refill_done && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (r_state == c_S_FILL) begin
                r_refill_done <= 1'b1;
            end else if (w_hit_done) begin
                r_refill_done <= 1'b0;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_sa
//  Purpose  : Self-checking bench for dcache_sa (WAYS=2, SETS=32). The model
//             keeps the architectural memory image plus a FIFO of resident
//             tags per set; round-robin replacement from reset is FIFO order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_sa;
    localparam int WAYS   = 2;
    localparam int SETS   = 32;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic [31:0]       p1_data_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [15:0]       hit_cnt_o;
    logic [15:0]       miss_cnt_o;

    dcache_sa #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [255:0] mem_line [int unsigned];
    logic [255:0] arch     [int unsigned];
    int res_tag   [SETS][WAYS];
    bit res_dirty [SETS][WAYS];
    int res_n     [SETS];
    int model_hits;
    int model_misses;

    typedef struct {
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [31:0] wdata;
        bit          exp_stall;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void ensure_line(int unsigned la);
        logic [255:0] r;
        if (!mem_line.exists(la)) begin
            r = rand256();
            mem_line[la] = r;
            arch[la]     = r;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) res_n[s] = 0;
        model_hits   = 0;
        model_misses = 0;
        foreach (arch[k]) arch[k] = mem_line[k];
    endfunction

    function automatic int find_way(int idx, int tag);
        for (int i = 0; i < res_n[idx]; i++) if (res_tag[idx][i] == tag) return i;
        return -1;
    endfunction

    // One memory transaction: wait for the request, check it, ack after a random delay
    task automatic serve(input bit is_wb, input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                         input logic [255:0] rdata, output logic [31:0] seen_addr,
                         output logic [255:0] seen_data);
        int n;
        int d;
        @(negedge clk);
        n = 0;
        while (!mem_enable_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("mem_enable_o request", mem_enable_o, 1'b1);
        chk("mem_write_o", mem_write_o, is_wb);
        chk("mem_addr_o", mem_addr_o, exp_addr);
        chk("stall during transfer", p1_stall_o, 1'b1);
        if (is_wb) chk("writeback line", mem_data_o, exp_wdata);
        seen_addr = mem_addr_o;
        seen_data = mem_data_o;
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk);
            chk("request held", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, is_wb, exp_addr});
        end
        mem_data_i = rdata;
        mem_ack_i  = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = rand256();
    endtask

    task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr, input logic [31:0] wdata,
                             output logic stall0, output logic [31:0] data_out, output bit wb_seen,
                             output logic [31:0] wb_addr, output logic [255:0] wb_data,
                             output logic [31:0] rd_addr);
        int idx, tag, pos, word, vtag;
        int unsigned la, vla;
        bit miss, exp_wb;
        logic [255:0] line, seen;
        logic [31:0] saddr;
        wb_seen = 0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        @(posedge clk);
        #1;
        p1_addr_i = addr; p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_data_i = wdata;
        @(negedge clk);
        stall0   = p1_stall_o;
        data_out = p1_data_o;
        if (!rd && !wr) begin
            chk("idle stall", p1_stall_o, 1'b0);
            chk("idle data", p1_data_o, 32'h0);
            chk("idle mem_enable_o", mem_enable_o, 1'b0);
            return;
        end
        idx  = int'((addr >> 5) % SETS);
        tag  = int'(addr >> 10);
        la   = addr >> 5;
        word = int'((addr >> 2) & 7);
        ensure_line(la);
        pos  = find_way(idx, tag);
        miss = (pos < 0);
        chk("stall on lookup", p1_stall_o, miss);
        chk("no request in lookup cycle", mem_enable_o, 1'b0);
        if (miss) begin
            model_misses++;
            exp_wb = 0;
            if (res_n[idx] == WAYS) begin
                vtag   = res_tag[idx][0];
                exp_wb = res_dirty[idx][0];
                vla    = (int'(vtag) << 5) | idx;
                for (int i = 1; i < WAYS; i++) begin
                    res_tag[idx][i-1]   = res_tag[idx][i];
                    res_dirty[idx][i-1] = res_dirty[idx][i];
                end
                res_n[idx]--;
                if (exp_wb) begin
                    serve(1'b1, vla << 5, arch[vla], rand256(), saddr, seen);
                    mem_line[vla] = seen;
                    wb_seen = 1; wb_addr = saddr; wb_data = seen;
                end
            end
            serve(1'b0, la << 5, '0, mem_line[la], saddr, seen);
            rd_addr = saddr;
            @(negedge clk);
            chk("stall in fill cycle", p1_stall_o, 1'b1);
            chk("no request in fill cycle", mem_enable_o, 1'b0);
            res_tag[idx][res_n[idx]]   = tag;
            res_dirty[idx][res_n[idx]] = 0;
            pos = res_n[idx];
            res_n[idx]++;
            @(negedge clk);
        end else begin
            model_hits++;
        end
        chk("stall released on hit", p1_stall_o, 1'b0);
        chk("no request on hit", mem_enable_o, 1'b0);
        line = arch[la];
        if (rd && !wr) chk("load data", p1_data_o, line[word*32 +: 32]);
        data_out = p1_data_o;
        if (wr) begin
            line[word*32 +: 32] = wdata;
            arch[la] = line;
            res_dirty[idx][pos] = 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        p1_MemRead_i = 0; p1_MemWrite_i = 0; mem_ack_i = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("reset stall", p1_stall_o, 1'b0);
        chk("reset mem_enable_o", mem_enable_o, 1'b0);
        chk("reset hit_cnt_o", hit_cnt_o, 16'h0);
        chk("reset miss_cnt_o", miss_cnt_o, 16'h0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_counters(input int eh, input int em);
        int exp_h, exp_m;
        exp_h = eh;
        exp_m = em;
`ifndef DCACHE_SA_STATS_EN
        exp_h = 0;
        exp_m = 0;
`endif
        @(posedge clk);
        #1;
        p1_MemRead_i = 0; p1_MemWrite_i = 0;
        @(negedge clk);
        chk("hit_cnt_o", hit_cnt_o, 16'(exp_h));
        chk("miss_cnt_o", miss_cnt_o, 16'(exp_m));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         st;
        logic [31:0]  d, wba, rda;
        logic [255:0] wbd, l40;
        bit           wbs;
        int           n, op;
        logic [31:0]  ra;

        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        p1_data_i = '0; p1_addr_i = '0; p1_MemRead_i = 0; p1_MemWrite_i = 0;
        mem_data_i = '0; mem_ack_i = 0;
        for (int i = 0; i < 8; i++) l40[i*32 +: 32] = 32'hA0000000 + i;
        l40[31:0] = 32'hDEADBEEF;
        mem_line[2] = l40;
        arch[2]     = l40;
        model_reset();

        tbl[0] = '{32'h40, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        tbl[1] = '{32'h48, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hA0000002};
        tbl[2] = '{32'h5C, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hA0000007};
        tbl[3] = '{32'h44, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678};
        tbl[4] = '{32'h58, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{32'h58, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
        tbl[6] = '{32'h4C, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{32'h4C, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0BADF00D};
        tbl[8] = '{32'h60, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[9] = '{32'h43, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset p1_data_o", p1_data_o, 32'h0);
        chk("reset p1_stall_o", p1_stall_o, 1'b0);
        chk("reset mem_enable_o", mem_enable_o, 1'b0);
        chk("reset mem_write_o", mem_write_o, 1'b0);
        chk("reset mem_addr_o", mem_addr_o, 32'h0);
        chk("reset mem_data_o", mem_data_o, 256'h0);
        chk("reset hit_cnt_o", hit_cnt_o, 16'h0);
        chk("reset miss_cnt_o", miss_cnt_o, 16'h0);
        rst = 1'b0;

        // Cold read miss
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("cold read stalls", st, 1'b1);
        chk("cold refill address", rda, 32'h40);
        chk("cold read data", d, 32'hDEADBEEF);

        // Write hit then read hit
        do_access(32'h44, 0, 1, 32'h12345678, st, d, wbs, wba, wbd, rda);
        chk("write hit stall", st, 1'b0);
        do_access(32'h44, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("read hit stall", st, 1'b0);
        chk("read-after-write data", d, 32'h12345678);

        // Table of single-cycle hits against the resident line at 0x40
        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, st, d, wbs, wba, wbd, rda);
            chk($sformatf("vec%0d stall", i), st, tbl[i].exp_stall);
            if (tbl[i].chk_data) chk($sformatf("vec%0d data", i), d, tbl[i].exp_data);
        end

        // Stray ack in IDLE must be ignored
        @(posedge clk);
        #1;
        p1_MemRead_i = 0; p1_MemWrite_i = 0; mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("stray ack: no request", mem_enable_o, 1'b0);
        chk("stray ack: no stall", p1_stall_o, 1'b0);
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("stray ack: still hits", st, 1'b0);

        // Conflict eviction with dirty victim
        do_access(32'h440, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("second way fill: no writeback", wbs, 1'b0);
        do_access(32'h840, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("dirty eviction writeback", wbs, 1'b1);
        chk("writeback address", wba, 32'h40);
        chk("writeback word1", wbd[63:32], 32'h12345678);
        chk("refill after writeback", rda, 32'h840);

        // Clean victim: straight to refill
        apply_reset();
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        do_access(32'h440, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        do_access(32'h840, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("clean victim: miss", st, 1'b1);
        chk("clean victim: no writeback", wbs, 1'b0);
        chk("clean victim: refill address", rda, 32'h840);

        // Reset during a refill
        apply_reset();
        @(posedge clk);
        #1;
        p1_addr_i = 32'h40; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_enable_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("refill request before abort", mem_enable_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort: mem_enable_o drops", mem_enable_o, 1'b0);
        chk("abort: p1_stall_o drops", p1_stall_o, 1'b0);
        @(negedge clk);
        p1_MemRead_i = 1'b0;
        rst = 1'b0;
        model_reset();
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        chk("re-read after abort misses", st, 1'b1);

        // Counter sequence
        apply_reset();
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        do_access(32'h40, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        do_access(32'h44, 0, 1, 32'h55AA55AA, st, d, wbs, wba, wbd, rda);
        do_access(32'h840, 1, 0, 32'h0, st, d, wbs, wba, wbd, rda);
        check_counters(2, 2);

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 5)
               | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            do_access(ra, (op >= 1 && op <= 5) || op == 9, op >= 6, $urandom, st, d, wbs, wba, wbd, rda);
        end
        check_counters(model_hits, model_misses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
